// File: rtl/i2c_reg_slave.sv
// Write-only I2C register slave: {DEV_ADDR,W}, {reg_addr[6:0],data[8]}, data[7:0].
// Each complete three-byte write commits one 7-bit address / 9-bit data pair.
module i2c_reg_slave #(
  parameter logic [6:0] DEV_ADDR = 7'h1A
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iI2C_SCLK,
  input  logic       iI2C_SDAT,
  output logic       oSDAT_OE,
  output logic       oREG_WE,
  output logic [6:0] oREG_ADDR,
  output logic [8:0] oREG_DATA,
  output logic [7:0] oWR_CNT,
  output logic       oBUSY
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ADDR      = 3'd1,
    ADDR_ACK  = 3'd2,
    BYTE1     = 3'd3,
    ACK1      = 3'd4,
    BYTE2     = 3'd5,
    ACK2      = 3'd6,
    WAIT_STOP = 3'd7
  } state_t;

  state_t     state, stateNext;

  logic       sclMeta, sclSync, sclPrev;
  logic       sdaMeta, sdaSync, sdaPrev;
  logic       sclRise, sclFall, startDet, stopDet;

  logic [7:0] shiftReg, shiftNext;
  logic [2:0] bitCnt, bitCntNext;
  logic [7:0] byte1Reg, byte1Next;
  logic       ackOn, ackOnNext;
  logic       oeNext, weNext;
  logic [6:0] addrNext;
  logic [8:0] dataNext;
  logic [7:0] cntNext;
  logic [7:0] byteIn;

  // Synchronizers and edge-history flops reset to 1 so an idle bus shows no edges.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      sclMeta <= 1'b1;
      sclSync <= 1'b1;
      sclPrev <= 1'b1;
      sdaMeta <= 1'b1;
      sdaSync <= 1'b1;
      sdaPrev <= 1'b1;
    end else begin
      sclMeta <= iI2C_SCLK;
      sclSync <= sclMeta;
      sclPrev <= sclSync;
      sdaMeta <= iI2C_SDAT;
      sdaSync <= sdaMeta;
      sdaPrev <= sdaSync;
    end
  end

  assign sclRise  = sclSync & ~sclPrev;
  assign sclFall  = ~sclSync & sclPrev;
  assign startDet = sclSync & sclPrev & sdaPrev & ~sdaSync;
  assign stopDet  = sclSync & sclPrev & ~sdaPrev & sdaSync;
  assign byteIn   = {shiftReg[6:0], sdaSync};
  assign oBUSY    = (state != IDLE);

  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state     <= IDLE;
      shiftReg  <= 8'd0;
      bitCnt    <= 3'd0;
      byte1Reg  <= 8'd0;
      ackOn     <= 1'b0;
      oSDAT_OE  <= 1'b0;
      oREG_WE   <= 1'b0;
      oREG_ADDR <= 7'd0;
      oREG_DATA <= 9'd0;
      oWR_CNT   <= 8'd0;
    end else begin
      state     <= stateNext;
      shiftReg  <= shiftNext;
      bitCnt    <= bitCntNext;
      byte1Reg  <= byte1Next;
      ackOn     <= ackOnNext;
      oSDAT_OE  <= oeNext;
      oREG_WE   <= weNext;
      oREG_ADDR <= addrNext;
      oREG_DATA <= dataNext;
      oWR_CNT   <= cntNext;
    end
  end

  always_comb begin
    stateNext  = state;
    shiftNext  = shiftReg;
    bitCntNext = bitCnt;
    byte1Next  = byte1Reg;
    ackOnNext  = ackOn;
    oeNext     = oSDAT_OE;
    weNext     = 1'b0;
    addrNext   = oREG_ADDR;
    dataNext   = oREG_DATA;
    cntNext    = oWR_CNT;

    if (stopDet) begin
      stateNext  = IDLE;
      oeNext     = 1'b0;
      ackOnNext  = 1'b0;
      bitCntNext = 3'd0;
    end else if (startDet) begin
      stateNext  = ADDR;
      oeNext     = 1'b0;
      ackOnNext  = 1'b0;
      bitCntNext = 3'd0;
      shiftNext  = 8'd0;
    end else begin
      case (state)
        ADDR, BYTE1, BYTE2: begin
          if (sclRise) begin
            shiftNext  = byteIn;
            bitCntNext = bitCnt + 3'd1;
            if (bitCnt == 3'd7) begin
              case (state)
                ADDR:    stateNext = (byteIn == {DEV_ADDR, 1'b0}) ? ADDR_ACK : WAIT_STOP;
                BYTE1: begin
                  byte1Next = byteIn;
                  stateNext = ACK1;
                end
                default: stateNext = ACK2;
              endcase
            end
          end
        end
        // Each ACK slot: first SCL fall pulls SDA low, the next one releases it.
        ADDR_ACK, ACK1, ACK2: begin
          if (sclFall) begin
            if (!ackOn) begin
              oeNext    = 1'b1;
              ackOnNext = 1'b1;
              if (state == ACK2) begin
                weNext   = 1'b1;
                addrNext = byte1Reg[7:1];
                dataNext = {byte1Reg[0], shiftReg};
                cntNext  = oWR_CNT + 8'd1;
              end
            end else begin
              oeNext    = 1'b0;
              ackOnNext = 1'b0;
              case (state)
                ADDR_ACK: stateNext = BYTE1;
                ACK1:     stateNext = BYTE2;
                default:  stateNext = WAIT_STOP;
              endcase
            end
          end
        end
        default: begin
          // IDLE and WAIT_STOP only leave on START/STOP.
        end
      endcase
    end
  end

endmodule
